lfsr_arbiter: RTL and testbench
===============================

# lfsr_arbiter

Shared pseudo-random source for the project. Owns a single 16-bit Fibonacci LFSR (polynomial x^16 + x^14 + x^13 + x^11) and serves N_REQ requesters with a req/ack handshake and round-robin arbitration. Each granted draw advances the LFSR by STEPS shifts before returning the value, so consecutive consumers never see correlated adjacent states. The block also handles seeding and lock-up protection, and can free-run between draws to absorb player-timing entropy.

## Interface

- N_REQ, 4, number of requesters (2..8)
- STEPS, 16, LFSR shifts per draw (1..255)
- SEED, 16'hACE1, reset seed and replacement for an all-zero seed (must be nonzero)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- seed_load  in  1  load seed_value into LFSR (honoured in IDLE only)
- seed_value  in  16  new seed
- livre  in  1  free-run enable: LFSR shifts every IDLE cycle with no other action
- req  in  N_REQ  per-requester draw request, level, held until ack
- ack  out  N_REQ  one-cycle grant-complete pulse, one-hot
- valor  out  16  random value from last completed draw
- grant_id  out  clog2(N_REQ)  index of current or last granted requester
- busy  out  1  high in SHIFT and ACK

## Operation

- LFSR step: fb = s[0]^s[2]^s[3]^s[5]; s <= {fb, s[15:1]}.
- Reset: s = SEED, valor = 0, ack = 0, busy = 0, grant_id = 0, state IDLE, round-robin pointer last = N_REQ-1 (requester 0 has first priority).
- FSM states IDLE, SHIFT, ACK.
- IDLE, priority order:
  - seed_load=1: s <= (seed_value==0) ? SEED : seed_value; stay IDLE; req ignored this cycle.
  - else any req bit set: grant first set bit searching from (last+1) mod N_REQ upward with wrap; grant_id <= winner; cnt <= STEPS; busy <= 1; go SHIFT. No free-run shift this cycle.
  - else livre=1: one LFSR step; stay IDLE.
  - else hold.
- SHIFT: one LFSR step per cycle, cnt decrements; on the cycle cnt==1 (last shift) go ACK. seed_load, livre, req changes ignored.
- ACK: ack[grant_id]=1 (registered, only that bit), valor = LFSR state after the STEPS shifts; last <= grant_id; next state IDLE, busy <= 0. No LFSR step.
- Requester dropping req during SHIFT: draw completes, ack still pulsed, value discarded by requester; no abort.
- Requester must deassert req in the cycle after ack, otherwise it re-enters arbitration and is served again only after all other pending requesters.
- LFSR never reaches zero (nonzero seed enforced; polynomial is maximal length, period 65535).

## Timing

- req sampled in IDLE at edge E0; SHIFT occupies edges E1..E_STEPS; ack and valor valid in the cycle after edge E_STEPS+... i.e. ack high for exactly one cycle starting STEPS+1 edges after E0.
- Back-to-back: next grant decision at the IDLE cycle following ACK; throughput one draw per STEPS+2 cycles.
- valor updates only on entry to ACK; holds otherwise, including across seed_load.
- ack, valor, grant_id, busy all registered; no combinational req→ack path.
- Reset asserted mid-SHIFT/ACK: immediately returns to reset values; pending draw lost, no ack.

## Test plan

- Reset: all outputs per reset list; with N_REQ=4, STEPS=1, livre=0, pulse req[0] → ack[0] one cycle, valor=16'h5670, grant_id=0; second draw by req[0] → valor=16'hAB38.
- Round-robin: STEPS=1, req=4'b1111 held, each requester drops req after its ack then re-raises → ack order 0,1,2,3,0; never two ack bits set.
- Seeding: seed_load with seed_value=0 then draw (STEPS=1) → valor=16'h5670; seed_load with seed_value=16'hACE1 during SHIFT → ignored, draw value unchanged from unseeded reference.
- Simultaneous seed_load and req[2] in IDLE → seed loaded, no grant that cycle; grant to 2 next cycle.
- Default STEPS=16: req[1] at E0 → ack[1] exactly 17 edges later, valor equals 16 steps from SEED (compare with model); livre=1 idle cycles shift state per model.
- Reset asserted during SHIFT → ack never pulses, busy=0, next draw with STEPS=1 gives 16'h5670.

Source files
------------

// File: rtl/lfsr_arbiter.sv
// ---------------------------------------------------------------------------
// lfsr_arbiter
//
// Shared pseudo-random source. A single 16-bit Fibonacci LFSR
// (x^16 + x^14 + x^13 + x^11) serves N_REQ requesters through a level req /
// one-cycle ack handshake with round-robin arbitration. Every granted draw
// advances the LFSR by STEPS shifts. The value is then published on valor,
// so consecutive consumers never see adjacent states. While idle the LFSR
// can free-run, which turns the unpredictable timing of requests into
// entropy. It can also be reseeded. An all-zero seed is replaced by SEED,
// so the register can never lock up at zero.
//
// Ports
//   clock       in   1        system clock, rising edge
//   reset       in   1        asynchronous, active-high
//   seed_load   in   1        load seed_value into the LFSR (IDLE only)
//   seed_value  in   16       new seed (zero is replaced by SEED)
//   livre       in   1        free-run: one LFSR step per otherwise idle cycle
//   req         in   N_REQ    per-requester draw request, held until ack
//   ack         out  N_REQ    one-cycle, one-hot draw-complete pulse
//   valor       out  16       value of the last completed draw
//   grant_id    out  ID_W     current or last granted requester
//   busy        out  1        high while a draw is in SHIFT or ACK
// ---------------------------------------------------------------------------
module lfsr_arbiter #(
  parameter int          N_REQ = 4,        // 2..8
  parameter int          STEPS = 16,       // 1..255
  parameter logic [15:0] SEED  = 16'hACE1, // nonzero
  localparam int         ID_W  = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [15:0]      seed_value,
  input  logic             livre,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [15:0]      valor,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [15:0]     lfsr;
  logic [7:0]      cnt;
  logic [ID_W-1:0] last;

  // Arbitration result.
  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;

  // Control strobes decoded from the state.
  logic            do_seed;
  logic            do_grant;
  logic            do_step;
  logic            do_ack;

  // One Fibonacci step. Taps 16/14/13/11 map to bits 0/2/3/5 of a
  // right-shifting register.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // -------------------------------------------------------------------------
  // Round-robin search: the first set req bit starting at (last+1) mod N_REQ,
  // wrapping upward. The modulo is written as a compare-and-subtract so that
  // it works for N_REQ values that are not powers of two.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch,
    // otherwise a path that leaves it unassigned infers a latch.
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (last >= ID_W'(N_REQ - 1 - i)) begin
        cand = last - ID_W'(N_REQ - 1 - i);
      end else begin
        cand = last + ID_W'(i + 1);
      end
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        // A seed load takes the whole cycle. Requests wait one cycle.
        if (!seed_load && pick_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 8'd1) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output decode (strobes for the registered datapath below)
  // -------------------------------------------------------------------------
  always_comb begin
    do_seed  = 1'b0;
    do_grant = 1'b0;
    do_step  = 1'b0;
    do_ack   = 1'b0;
    unique case (state)
      IDLE: begin
        if (seed_load) begin
          do_seed = 1'b1;
        end else if (pick_valid) begin
          do_grant = 1'b1;
        end else if (livre) begin
          do_step = 1'b1;
        end
      end
      SHIFT: begin
        do_step = 1'b1;
      end
      ACK: begin
        do_ack = 1'b1;
      end
      default: begin
        do_seed = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath. All outputs are registered, so there is no combinational path
  // from req to ack. ack and valor are published together on the edge that
  // leaves ACK. The LFSR does not step in ACK, so valor is exactly the state
  // after STEPS shifts.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr     <= SEED;
      cnt      <= '0;
      last     <= ID_W'(N_REQ - 1);
      grant_id <= '0;
      ack      <= '0;
      valor    <= '0;
      busy     <= 1'b0;
    end else begin
      ack <= '0;

      if (do_seed) begin
        lfsr <= (seed_value == 16'h0000) ? SEED : seed_value;
      end else if (do_step) begin
        lfsr <= lfsr_next(lfsr);
      end

      if (do_grant) begin
        grant_id <= pick_id;
        cnt      <= 8'(STEPS);
        busy     <= 1'b1;
      end else if (state == SHIFT) begin
        cnt <= cnt - 8'd1;
      end

      if (do_ack) begin
        ack   <= N_REQ'(1) << grant_id;
        valor <= lfsr;
        last  <= grant_id;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lfsr_arbiter
//
// Directed bench for lfsr_arbiter. Two instances share the clock and reset:
// dut1 (STEPS=1) covers the hand-computed sequences, and dut16 (default
// STEPS=16) covers latency and free-run behaviour. Inputs are driven and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lfsr_arbiter;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock;
  logic        reset;

  logic        seed_load1, livre1, busy1;
  logic [15:0] seed_value1, valor1;
  logic [3:0]  req1, ack1;
  logic [1:0]  grant_id1;

  logic        seed_load16, livre16, busy16;
  logic [15:0] seed_value16, valor16;
  logic [3:0]  req16, ack16;
  logic [1:0]  grant_id16;

  int          checks;
  int          errors;
  logic [15:0] m1;
  logic [15:0] m16;

  lfsr_arbiter #(.N_REQ(4), .STEPS(1), .SEED(SEED)) dut1 (
    .clock(clock), .reset(reset), .seed_load(seed_load1),
    .seed_value(seed_value1), .livre(livre1), .req(req1), .ack(ack1),
    .valor(valor1), .grant_id(grant_id1), .busy(busy1)
  );

  lfsr_arbiter #(.N_REQ(4), .STEPS(16), .SEED(SEED)) dut16 (
    .clock(clock), .reset(reset), .seed_load(seed_load16),
    .seed_value(seed_value16), .livre(livre16), .req(req16), .ack(ack16),
    .valor(valor16), .grant_id(grant_id16), .busy(busy16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One draw on dut1 (STEPS=1). Optionally pulses seed_load during SHIFT,
  // which must have no effect.
  task automatic draw1(input logic [1:0] idx, input bit seed_mid,
                       input string tag);
    int         n;
    logic [3:0] exp_ack;
    @(negedge clock);
    req1[idx] = 1'b1;
    n = 0;
    while (ack1 == 4'b0000 && n < 40) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        check({tag, "_busy"}, {31'b0, busy1}, 32'd1);
        if (seed_mid) begin
          seed_load1  = 1'b1;
          seed_value1 = 16'hACE1;
        end
      end
      if (n == 2) seed_load1 = 1'b0;
    end
    m1 = lfsr_step(m1);
    exp_ack = 4'b0001 << idx;
    check({tag, "_lat"}, n, 32'd3);
    check({tag, "_ack"}, {28'b0, ack1}, {28'b0, exp_ack});
    check({tag, "_valor"}, {16'b0, valor1}, {16'b0, m1});
    check({tag, "_gid"}, {30'b0, grant_id1}, {30'b0, idx});
    check({tag, "_idle"}, {31'b0, busy1}, 32'd0);
    req1[idx] = 1'b0;
  endtask

  // One draw on dut16 (STEPS=16): ack is expected 17 edges after the grant edge.
  task automatic draw16(input logic [1:0] idx, input string tag);
    int         n;
    logic [3:0] exp_ack;
    req16[idx] = 1'b1;
    n = 0;
    while (ack16 == 4'b0000 && n < 60) begin
      @(negedge clock);
      n++;
      if (n == 1) check({tag, "_busy"}, {31'b0, busy16}, 32'd1);
    end
    for (int i = 0; i < 16; i++) m16 = lfsr_step(m16);
    exp_ack = 4'b0001 << idx;
    check({tag, "_lat"}, n, 32'd18);
    check({tag, "_ack"}, {28'b0, ack16}, {28'b0, exp_ack});
    check({tag, "_valor"}, {16'b0, valor16}, {16'b0, m16});
    check({tag, "_gid"}, {30'b0, grant_id16}, {30'b0, idx});
    req16[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [15:0] held;
    logic [3:0]  exp_ack;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    seed_load1 = 1'b0; seed_value1 = '0; livre1 = 1'b0; req1 = '0;
    seed_load16 = 1'b0; seed_value16 = '0; livre16 = 1'b0; req16 = '0;

    // ---- reset values ----
    repeat (2) @(negedge clock);
    check("rst_ack", {28'b0, ack1}, 32'd0);
    check("rst_valor", {16'b0, valor1}, 32'd0);
    check("rst_gid", {30'b0, grant_id1}, 32'd0);
    check("rst_busy", {31'b0, busy1}, 32'd0);
    reset = 1'b0;
    m1  = SEED;
    m16 = SEED;
    @(negedge clock);

    // ---- STEPS=16: latency and value, then free-run ----
    draw16(2'd1, "d16a");
    held = valor16;
    livre16 = 1'b1;
    repeat (5) @(negedge clock);
    livre16 = 1'b0;
    for (int i = 0; i < 5; i++) m16 = lfsr_step(m16);
    check("d16_valor_hold", {16'b0, valor16}, {16'b0, held});
    draw16(2'd3, "d16b");

    // ---- STEPS=1: two hand-computed draws by requester 0 ----
    draw1(2'd0, 1'b0, "a1");
    check("a1_hand", {16'b0, valor1}, 32'h5670);
    @(negedge clock);
    check("a1_width", {28'b0, ack1}, 32'd0);
    draw1(2'd0, 1'b0, "a2");
    check("a2_hand", {16'b0, valor1}, 32'hAB38);

    // ---- round robin with all four requesters ----
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m1 = SEED;
    req1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (ack1 == 4'b0000 && n < 20) begin
        @(negedge clock);
        n++;
      end
      m1 = lfsr_step(m1);
      exp_ack = 4'b0001 << (k % 4);
      check("rr_ack", {28'b0, ack1}, {28'b0, exp_ack});
      check("rr_valor", {16'b0, valor1}, {16'b0, m1});
      if (k == 4) begin
        req1 = 4'b0000;
      end else begin
        req1 = req1 & ~exp_ack;
        @(negedge clock);
        check("rr_width", {28'b0, ack1}, 32'd0);
        req1 = req1 | exp_ack;
      end
    end

    // ---- zero seed is replaced by SEED ----
    @(negedge clock);
    seed_load1  = 1'b1;
    seed_value1 = 16'h0000;
    @(negedge clock);
    seed_load1 = 1'b0;
    m1 = SEED;
    draw1(2'd1, 1'b0, "s0");
    check("s0_hand", {16'b0, valor1}, 32'h5670);

    // ---- seed_load during SHIFT is ignored ----
    draw1(2'd2, 1'b1, "smid");
    check("smid_hand", {16'b0, valor1}, 32'hAB38);

    // ---- seed_load and req[2] together: seed wins, grant next cycle ----
    @(negedge clock);
    seed_load1  = 1'b1;
    seed_value1 = 16'h1234;
    req1[2]     = 1'b1;
    @(negedge clock);
    check("sim_no_grant", {31'b0, busy1}, 32'd0);
    seed_load1 = 1'b0;
    n = 0;
    while (ack1 == 4'b0000 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("sim_lat", n, 32'd3);
    check("sim_ack", {28'b0, ack1}, 32'h4);
    check("sim_gid", {30'b0, grant_id1}, 32'd2);
    check("sim_valor", {16'b0, valor1}, 32'h091A);
    req1[2] = 1'b0;
    m1 = 16'h091A;

    // ---- reset in the middle of SHIFT ----
    @(negedge clock);
    req1[0] = 1'b1;
    @(negedge clock);
    check("rmid_busy", {31'b0, busy1}, 32'd1);
    reset = 1'b1;
    #1;
    check("rmid_busy_clr", {31'b0, busy1}, 32'd0);
    req1[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rmid_no_ack", {28'b0, ack1}, 32'd0);
    end
    reset = 1'b0;
    m1 = SEED;
    @(negedge clock);
    check("rmid_no_ack_after", {28'b0, ack1}, 32'd0);
    draw1(2'd0, 1'b0, "rpost");
    check("rpost_hand", {16'b0, valor1}, 32'h5670);

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
